gate_activation_unit: RTL and testbench

// Downstream stage of the hidden and input MAC units inside one LSTM gate. It pairs the
// per-neuron input-MAC and hidden-MAC dot products and adds the neuron bias. It requantizes
// the sum to DATA_WIDTH fixed point, then applies hard-sigmoid or hard-tanh. It writes one

---
 rtl/lstm_fixed_pkg.sv | 26 ++
 rtl/gate_activation_unit_if.sv | 27 ++
 rtl/hard_activation.sv | 24 ++
 rtl/gate_activation_unit.sv | 152 +++++++++++++++
 tb/tb_gate_activation_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_fixed_pkg.sv
// Fixed-point format shared by the LSTM gate datapath: widths, constants,
// FSM state type and the requantization saturator.
package lstm_fixed_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int OUTPUT_WIDTH = 32;
  localparam int FRAC_SZ      = 10;
  localparam int SUM_WIDTH    = OUTPUT_WIDTH + 2;

  localparam int ACT_SIGMOID = 0;
  localparam int ACT_TANH    = 1;

  localparam logic signed [DATA_WIDTH-1:0] ONE_Q     = DATA_WIDTH'(1 << FRAC_SZ);
  localparam logic signed [DATA_WIDTH-1:0] NEG_ONE_Q = DATA_WIDTH'(-(1 << FRAC_SZ));
  localparam logic signed [DATA_WIDTH-1:0] HALF_Q    = DATA_WIDTH'(1 << (FRAC_SZ - 1));

  localparam logic signed [SUM_WIDTH-1:0] SAT_HI = SUM_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SUM_WIDTH-1:0] SAT_LO = SUM_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} gau_state_e;

  function automatic logic signed [DATA_WIDTH-1:0] sat_to_data(input logic signed [SUM_WIDTH-1:0] v);
    if (v > SAT_HI)      sat_to_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < SAT_LO) sat_to_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                 sat_to_data = v[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/gate_activation_unit_if.sv
// MAC-result strobes, bias ROM port and gate-buffer write port of one gate.
interface gate_activation_unit_if import lstm_fixed_pkg::*; #(
  parameter int ADDR_WIDTH = 7
);
  logic                           start;
  logic                           x_valid;
  logic signed [OUTPUT_WIDTH-1:0] x_element;
  logic                           h_valid;
  logic signed [OUTPUT_WIDTH-1:0] h_element;
  logic [ADDR_WIDTH-1:0]          bias_addr;
  logic signed [DATA_WIDTH-1:0]   bias_data;
  logic                           gate_wr_en;
  logic [ADDR_WIDTH-1:0]          gate_wr_addr;
  logic signed [DATA_WIDTH-1:0]   gate_wr_data;
  logic                           busy;
  logic                           done;
  logic                           overflow_err;

  modport master (
    output start, x_valid, x_element, h_valid, h_element, bias_data,
    input  bias_addr, gate_wr_en, gate_wr_addr, gate_wr_data, busy, done, overflow_err
  );
  modport slave (
    input  start, x_valid, x_element, h_valid, h_element, bias_data,
    output bias_addr, gate_wr_en, gate_wr_addr, gate_wr_data, busy, done, overflow_err
  );
endinterface

// File: rtl/hard_activation.sv
// Piecewise-linear activation on a Q.FRAC_SZ value: hard-sigmoid or hard-tanh.
module hard_activation import lstm_fixed_pkg::*; #(
  parameter int ACT_TYPE = ACT_SIGMOID
) (
  input  logic signed [DATA_WIDTH-1:0] q,
  output logic signed [DATA_WIDTH-1:0] act
);
  logic signed [DATA_WIDTH-1:0] sig_lin;

  always_comb begin
    // q/4 + 1/2 cannot overflow DATA_WIDTH, so no widening is needed
    sig_lin = (q >>> 2) + HALF_Q;
    act     = '0;
    if (ACT_TYPE == ACT_TANH) begin
      if (q > ONE_Q)          act = ONE_Q;
      else if (q < NEG_ONE_Q) act = NEG_ONE_Q;
      else                    act = q;
    end else begin
      if (sig_lin[DATA_WIDTH-1]) act = '0;
      else if (sig_lin > ONE_Q)  act = ONE_Q;
      else                       act = sig_lin;
    end
  end
endmodule

// File: rtl/gate_activation_unit.sv
// Pairs x/h MAC results per neuron, adds bias, requantizes, activates and
// writes one gate element per neuron; three-stage pipeline after fire.
module gate_activation_unit import lstm_fixed_pkg::*; #(
  parameter int NUM_UNITS  = 100,
  parameter int ADDR_WIDTH = 7,
  parameter int ACT_TYPE   = ACT_SIGMOID
) (
  input logic                   clk,
  input logic                   rst,
  gate_activation_unit_if.slave bus
);
  localparam int STAGES = 3;
  localparam int IDX_W  = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] UNITS    = IDX_W'(NUM_UNITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  gau_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           x_full_q, x_full_d, h_full_q, h_full_d;
  logic signed [OUTPUT_WIDTH-1:0] x_slot_q, x_slot_d, h_slot_q, h_slot_d;
  logic                           bias_rdy_q, bias_rdy_d;
  logic                           ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [STAGES:1]                vld_pipe_q, vld_pipe_d;
  logic signed [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0]   qv_q, qv_d, wr_data_q, wr_data_d, act_c;
  logic [ADDR_WIDTH-1:0]          a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic                           fire;

  assign fire = (state_q == ST_RUN) && x_full_q && h_full_q && bias_rdy_q && (idx_q < UNITS);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_full_d   = x_full_q;
    h_full_d   = h_full_q;
    x_slot_d   = x_slot_q;
    h_slot_d   = h_slot_q;
    bias_rdy_d = 1'b0;
    ovf_d      = ovf_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d  = ST_RUN;
        idx_d    = '0;
        ovf_d    = 1'b0;
        x_full_d = 1'b0;
        h_full_d = 1'b0;
      end
      ST_RUN: begin
        // ROM data for the current idx is valid one cycle after idx settles
        bias_rdy_d = ~fire;
        if (fire) begin
          x_full_d = 1'b0;
          h_full_d = 1'b0;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_FLUSH;
        end
        if (bus.x_valid) begin
          if (x_full_q && !fire) ovf_d = 1'b1;
          else begin
            x_slot_d = bus.x_element;
            x_full_d = 1'b1;
          end
        end
        if (bus.h_valid) begin
          if (h_full_q && !fire) ovf_d = 1'b1;
          else begin
            h_slot_d = bus.h_element;
            h_full_d = 1'b1;
          end
        end
      end
      ST_FLUSH: if (vld_pipe_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], fire};
    sum_d      = sum_q;
    a1_d       = a1_q;
    qv_d       = qv_q;
    a2_d       = a2_q;
    wr_data_d  = wr_data_q;
    a3_d       = a3_q;
    if (fire) begin
      sum_d = SUM_WIDTH'(x_slot_q) + SUM_WIDTH'(h_slot_q)
            + (SUM_WIDTH'(bus.bias_data) <<< FRAC_SZ);
      a1_d  = idx_q[ADDR_WIDTH-1:0];
    end
    if (vld_pipe_q[1]) begin
      qv_d = sat_to_data(sum_q >>> FRAC_SZ);
      a2_d = a1_q;
    end
    if (vld_pipe_q[2]) begin
      wr_data_d = act_c;
      a3_d      = a2_q;
    end
  end

  hard_activation #(.ACT_TYPE(ACT_TYPE)) u_act (.q(qv_q), .act(act_c));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      x_full_q   <= 1'b0;
      h_full_q   <= 1'b0;
      x_slot_q   <= '0;
      h_slot_q   <= '0;
      bias_rdy_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      sum_q      <= '0;
      a1_q       <= '0;
      qv_q       <= '0;
      a2_q       <= '0;
      wr_data_q  <= '0;
      a3_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_full_q   <= x_full_d;
      h_full_q   <= h_full_d;
      x_slot_q   <= x_slot_d;
      h_slot_q   <= h_slot_d;
      bias_rdy_q <= bias_rdy_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      sum_q      <= sum_d;
      a1_q       <= a1_d;
      qv_q       <= qv_d;
      a2_q       <= a2_d;
      wr_data_q  <= wr_data_d;
      a3_q       <= a3_d;
    end
  end

  assign bus.bias_addr    = idx_q[ADDR_WIDTH-1:0];
  assign bus.gate_wr_en   = vld_pipe_q[STAGES];
  assign bus.gate_wr_addr = a3_q;
  assign bus.gate_wr_data = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_gate_activation_unit.sv
// Directed bench: one hard-tanh and one hard-sigmoid unit, four neurons each.
module tb_gate_activation_unit;
  import lstm_fixed_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  gate_activation_unit_if #(.ADDR_WIDTH(2)) bt ();
  gate_activation_unit_if #(.ADDR_WIDTH(2)) bs ();

  gate_activation_unit #(.NUM_UNITS(4), .ADDR_WIDTH(2), .ACT_TYPE(ACT_TANH))
    dut_t (.clk(clk), .rst(rst), .bus(bt));
  gate_activation_unit #(.NUM_UNITS(4), .ADDR_WIDTH(2), .ACT_TYPE(ACT_SIGMOID))
    dut_s (.clk(clk), .rst(rst), .bus(bs));

  // index 0 = tanh unit, 1 = sigmoid unit
  logic [1:0]               start_v = '0, xv_v = '0, hv_v = '0;
  logic signed [31:0]       xe_v [2];
  logic signed [31:0]       he_v [2];
  logic signed [15:0]       bias_mem [2][4];

  assign bt.start = start_v[0];  assign bs.start = start_v[1];
  assign bt.x_valid = xv_v[0];   assign bs.x_valid = xv_v[1];
  assign bt.h_valid = hv_v[0];   assign bs.h_valid = hv_v[1];
  assign bt.x_element = xe_v[0]; assign bs.x_element = xe_v[1];
  assign bt.h_element = he_v[0]; assign bs.h_element = he_v[1];

  always @(posedge clk) begin
    bt.bias_data <= bias_mem[0][bt.bias_addr];
    bs.bias_data <= bias_mem[1][bs.bias_addr];
  end

  logic [1:0]         busy_v, done_v, ovf_v, wen_v;
  logic [1:0]         badr_v [2];
  logic [1:0]         wadr_v [2];
  logic signed [15:0] wdat_v [2];
  assign busy_v = {bs.busy, bt.busy};
  assign done_v = {bs.done, bt.done};
  assign ovf_v  = {bs.overflow_err, bt.overflow_err};
  assign wen_v  = {bs.gate_wr_en, bt.gate_wr_en};
  assign badr_v[0] = bt.bias_addr;    assign badr_v[1] = bs.bias_addr;
  assign wadr_v[0] = bt.gate_wr_addr; assign wadr_v[1] = bs.gate_wr_addr;
  assign wdat_v[0] = bt.gate_wr_data; assign wdat_v[1] = bs.gate_wr_data;

  int                 wr_cnt [2] = '{0, 0};
  int                 rd_ptr [2] = '{0, 0};
  logic [1:0]         log_a [2][32];
  logic signed [15:0] log_d [2][32];

  always @(negedge clk) begin
    if (bt.gate_wr_en === 1'b1) begin
      log_a[0][wr_cnt[0][4:0]] <= bt.gate_wr_addr;
      log_d[0][wr_cnt[0][4:0]] <= bt.gate_wr_data;
      wr_cnt[0] <= wr_cnt[0] + 1;
    end
    if (bs.gate_wr_en === 1'b1) begin
      log_a[1][wr_cnt[1][4:0]] <= bs.gate_wr_addr;
      log_d[1][wr_cnt[1][4:0]] <= bs.gate_wr_data;
      wr_cnt[1] <= wr_cnt[1] + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  task automatic strobe(input int d, input bit dx, input bit dh,
                        input logic signed [31:0] xv, input logic signed [31:0] hv);
    xv_v[d] = dx;
    hv_v[d] = dh;
    xe_v[d] = xv;
    he_v[d] = hv;
    tick();
    xv_v[d] = 1'b0;
    hv_v[d] = 1'b0;
  endtask

  task automatic expect_next(input int d, input string tag, input int addr, input int data);
    for (int i = 0; i < 12 && wr_cnt[d] <= rd_ptr[d]; i++) tick();
    chk({tag, "_seen"}, wr_cnt[d] > rd_ptr[d], 1);
    if (wr_cnt[d] > rd_ptr[d]) begin
      chk({tag, "_addr"}, log_a[d][rd_ptr[d][4:0]], addr);
      chk({tag, "_data"}, log_d[d][rd_ptr[d][4:0]], data);
      rd_ptr[d]++;
    end
  endtask

  task automatic wait_done(input int d, input string tag);
    for (int i = 0; i < 12 && done_v[d] !== 1'b1; i++) tick();
    chk({tag, "_done"}, done_v[d], 1);
    chk({tag, "_busy_drop"}, busy_v[d], 0);
    tick();
    chk({tag, "_done_pulse"}, done_v[d], 0);
    chk({tag, "_busy_after"}, busy_v[d], 0);
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_busy"}, busy_v[d], 0);
    chk({tag, "_done"}, done_v[d], 0);
    chk({tag, "_wren"}, wen_v[d], 0);
    chk({tag, "_ovf"}, ovf_v[d], 0);
    chk({tag, "_badr"}, badr_v[d], 0);
    chk({tag, "_wadr"}, wadr_v[d], 0);
    chk({tag, "_wdat"}, wdat_v[d], 0);
  endtask

  int cnt0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      xe_v[d] = '0;
      he_v[d] = '0;
      for (int k = 0; k < 4; k++) bias_mem[d][k] = '0;
    end
    bias_mem[1][0] = -16'sd2048;
    bias_mem[1][3] = 16'sd1024;
    rst = 1'b0;
    tick(); tick();
    chk_reset(0, "rst_t");
    chk_reset(1, "rst_s");
    rst = 1'b1;
    tick();

    // tanh run: latency, first-h-wins overflow, saturation both ways
    start_run(0);
    chk("a_busy", busy_v[0], 1);
    tick();
    strobe(0, 1, 1, 32'sd1048576, 32'sd0);
    tick(); tick();
    chk("t1_wren_early", wen_v[0], 0);
    tick();
    chk("t1_wren", wen_v[0], 1);
    chk("t1_addr", wadr_v[0], 0);
    chk("t1_data", wdat_v[0], 1024);
    expect_next(0, "t1_log", 0, 1024);

    strobe(0, 0, 1, 0, 32'sd524288);
    tick(); tick();
    strobe(0, 0, 1, 0, -32'sd524288);
    chk("t4_ovf_set", ovf_v[0], 1);
    tick(); tick(); tick(); tick();
    strobe(0, 1, 0, 32'sd0, 0);
    expect_next(0, "t4", 1, 512);
    chk("t4_ovf_sticky", ovf_v[0], 1);

    strobe(0, 1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    expect_next(0, "t3_pos", 2, 1024);
    strobe(0, 1, 1, 32'h8000_0000, 32'h8000_0000);
    expect_next(0, "t3_neg", 3, -1024);
    wait_done(0, "a");
    chk("a_ovf_kept", ovf_v[0], 1);

    // sigmoid run
    start_run(1);
    strobe(1, 1, 1, 0, 0);
    expect_next(1, "s_neg2", 0, 0);
    strobe(1, 1, 1, 0, 0);
    expect_next(1, "s_zero", 1, 512);
    strobe(1, 1, 1, 32'sd2097152, 32'sd2097152);
    expect_next(1, "s_clamp", 2, 1024);
    strobe(1, 1, 1, 0, 0);
    expect_next(1, "s_bias", 3, 768);
    wait_done(1, "s");

    // mixed arrival order; unit1 x lands in unit0's fire cycle
    bias_mem[0][2] = 16'sd300;
    start_run(0);
    chk("t5_ovf_clr", ovf_v[0], 0);
    strobe(0, 1, 0, 32'sd102400, 0);
    tick();
    strobe(0, 0, 1, 0, 32'sd0);
    strobe(0, 1, 0, 32'sd0, 0);
    tick();
    strobe(0, 0, 1, 0, -32'sd204800);
    expect_next(0, "t5_u0", 0, 100);
    expect_next(0, "t5_u1", 1, -200);
    strobe(0, 1, 1, 0, 0);
    expect_next(0, "t5_u2", 2, 300);
    strobe(0, 1, 0, 32'sd1024000, 0);
    strobe(0, 0, 1, 0, 32'sd512000);
    expect_next(0, "t5_u3", 3, 1024);
    chk("t5_ovf", ovf_v[0], 0);
    wait_done(0, "b");

    cnt0 = wr_cnt[0];
    strobe(0, 1, 1, 32'sd1048576, 32'sd1048576);
    repeat (6) tick();
    chk("idle_nowr", wr_cnt[0], cnt0);
    chk("idle_busy", busy_v[0], 0);

    // mid-run reset discards the in-flight element
    bias_mem[0][2] = 16'sd0;
    start_run(0);
    strobe(0, 1, 0, 32'sd1048576, 0);
    strobe(0, 1, 0, -32'sd1048576, 0);
    strobe(0, 0, 1, 0, 32'sd0);
    expect_next(0, "t6_u0", 0, 1024);
    chk("t6_ovf", ovf_v[0], 1);
    strobe(0, 1, 1, 32'sd524288, 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset(0, "t6_rst");
    cnt0 = wr_cnt[0];
    repeat (6) tick();
    chk("t6_nowr", wr_cnt[0], cnt0);

    start_run(0);
    chk("t6_restart_ovf", ovf_v[0], 0);
    chk("t6_restart_badr", badr_v[0], 0);
    strobe(0, 1, 1, 32'sd524288, 0);
    expect_next(0, "t6_restart", 0, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
